// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing constants, colour constants and
// coordinate/pixel types used by the timing generator and the overlay generators.
package vga_timing_pkg;

  localparam int unsigned CNT_W    = 10;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

  typedef logic [CNT_W-1:0] coord_t;
  typedef logic [5:0]       rgb_t;   // RRGGBB

  localparam rgb_t COLOR_BLACK = 6'b00_00_00;
  localparam rgb_t COLOR_GOLD  = 6'b11_10_00;
  localparam rgb_t COLOR_RED   = 6'b11_00_00;

  // Unsigned half-open window test: lo <= v < hi.
  function automatic logic in_window(coord_t v, int unsigned lo, int unsigned hi);
    return (32'(v) >= lo) && (32'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_if: pixel-coordinate bus between the timing generator (master)
// and the combinational overlay generators (slave).
//   x, y        current column/row
//   active      inside the visible 640x480 area
//   line_start  first pixel of a line (qualified by the pixel strobe)
//   frame_start first pixel of a frame (qualified by the pixel strobe)
//   rgb_in      merged RRGGBB returned by the generators for the current x/y
interface vga_timing_if import vga_timing_pkg::*; ();

  coord_t x;
  coord_t y;
  logic   active;
  logic   line_start;
  logic   frame_start;
  rgb_t   rgb_in;

  modport master (
    output x, y, active, line_start, frame_start,
    input  rgb_in
  );

  modport slave (
    input  x, y, active, line_start, frame_start,
    output rgb_in
  );

endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
// Counts 0..ACTIVE+FP+SYNC+BP-1 on each inc and wraps to 0.
//   clk, rst   clock, asynchronous active-high reset
//   inc        advance strobe
//   cnt        current position
//   wrap       comb: inc while at the last position (the counter returns to 0 next)
//   in_active  comb: cnt inside the visible region
//   in_sync    comb: cnt inside the sync pulse window
module vga_axis_counter import vga_timing_pkg::*; #(
  parameter int unsigned ACTIVE = H_ACTIVE,
  parameter int unsigned FP     = H_FP,
  parameter int unsigned SYNC   = H_SYNC,
  parameter int unsigned BP     = H_BP
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   inc,
  output coord_t cnt,
  output logic   wrap,
  output logic   in_active,
  output logic   in_sync
);

  localparam int unsigned TOTAL   = ACTIVE + FP + SYNC + BP;
  localparam coord_t      LAST    = coord_t'(TOTAL - 1);
  localparam int unsigned SYNC_LO = ACTIVE + FP;
  localparam int unsigned SYNC_HI = ACTIVE + FP + SYNC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 10'd1;
    end
  end

  assign wrap      = inc && (cnt == LAST);
  assign in_active = 32'(cnt) < ACTIVE;
  assign in_sync   = in_window(cnt, SYNC_LO, SYNC_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing source.
// Walks the H_TOTAL x V_TOTAL raster, publishes x/y/active/line_start/
// frame_start to the overlay generators over the pix bus, and registers
// their rgb_in together with hsync/vsync so sync and colour leave aligned.
//   clk    pixel-domain clock
//   rst    asynchronous, active-high reset
//   en     pixel strobe; all state advances only while en=1
//   pix    vga_timing_if master (x, y, active, line_start, frame_start out; rgb_in in)
//   hsync  registered horizontal sync, asserted level SYNC_POL
//   vsync  registered vertical sync, asserted level SYNC_POL
//   rgb    registered pixel, black outside the active area
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  vga_timing_if.master        pix,
  output logic                hsync,
  output logic                vsync,
  output vga_timing_pkg::rgb_t rgb
);

  import vga_timing_pkg::*;

  localparam int unsigned LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (LINE_LEN > 1024 || FRAME_LINES > 1024) begin : g_size_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024 for 10-bit counters");
  end

  coord_t h_cnt;
  coord_t v_cnt;
  logic   h_wrap;
  logic   h_act;
  logic   h_sync_win;
  logic   v_act;
  logic   v_sync_win;
  logic   unused_v_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk       (clk),
    .rst       (rst),
    .inc       (en),
    .cnt       (h_cnt),
    .wrap      (h_wrap),
    .in_active (h_act),
    .in_sync   (h_sync_win)
  );

  // Vertical axis advances once per line, on the last pixel of the line.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk       (clk),
    .rst       (rst),
    .inc       (en & h_wrap),
    .cnt       (v_cnt),
    .wrap      (unused_v_wrap),
    .in_active (v_act),
    .in_sync   (v_sync_win)
  );

  assign pix.x           = h_cnt;
  assign pix.y           = v_cnt;
  assign pix.active      = h_act && v_act;
  assign pix.line_start  = en && (h_cnt == '0);
  assign pix.frame_start = en && (h_cnt == '0) && (v_cnt == '0);

  // One pipeline stage: sync decoded from cycle N leaves with the colour for cycle N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      rgb   <= COLOR_BLACK;
    end else if (en) begin
      hsync <= h_sync_win ? SYNC_POL : ~SYNC_POL;
      vsync <= v_sync_win ? SYNC_POL : ~SYNC_POL;
      rgb   <= pix.active ? pix.rgb_in : COLOR_BLACK;
    end
  end

endmodule
